// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between an instruction-fetch
// port and a data (load/store) port.
// Each access is a fixed sequence: sample in IDLE, WAIT_CYCLES+1 ACCESS
// cycles driving the RAM, then a one-cycle RESP carrying the ready pulse.
// Build option: define ARB_FAIR_EN for round-robin arbitration; the default
// build uses fixed priority with the data port winning.
//
// state  | meaning
// IDLE   | no access in flight; sample requests and grant one
// ACCESS | RAM driven from latched request; wait counter runs down
// RESP   | one-cycle ready pulse to the granted requester
module mem_port_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_ready_o,
   input  logic        dm_ce_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_sel_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ready_o,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_nxt;
   logic [3:0]  cnt_q;
   logic        gnt_dm_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] if_data_q;
   logic [31:0] dm_rdata_q;
   logic        pick_dm;
   logic        in_access;

`ifdef ARB_FAIR_EN
   logic        last_dm_q;

   // Round-robin: on contention grant the port that did not win last time.
   always_comb begin
      pick_dm = dm_ce_i & (~if_ce_i | ~last_dm_q);
   end

   // Remember which port won the most recent grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_dm_q <= 1'b0;
      else if (state_q == IDLE && (if_ce_i || dm_ce_i))
         last_dm_q <= pick_dm;
   end
`else
   // Fixed priority: data port always wins over fetch.
   always_comb begin
      pick_dm = dm_ce_i;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_nxt;
   end

   // Next-state decode and RAM/ready outputs decoded from the current state.
   always_comb begin
      state_nxt   = state_q;
      in_access   = 1'b0;
      ram_ce_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_sel_o   = 4'b0000;
      ram_addr_o  = 32'h0;
      ram_wdata_o = 32'h0;
      if_ready_o  = 1'b0;
      dm_ready_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_ce_i || dm_ce_i)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            in_access   = 1'b1;
            ram_ce_o    = 1'b1;
            ram_we_o    = we_q;
            ram_sel_o   = sel_q;
            ram_addr_o  = addr_q;
            ram_wdata_o = wdata_q;
            if (cnt_q == 4'd0)
               state_nxt = RESP;
         end
         RESP: begin
            if_ready_o = ~gnt_dm_q;
            dm_ready_o = gnt_dm_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stall is forced low in reset so every output reads 0 while rst is low.
   always_comb begin
      stallreq_o = rst & ((if_ce_i & ~if_ready_o) | (dm_ce_i & ~dm_ready_o));
   end

   // Grant latch, wait counter and read-data capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= 4'd0;
         gnt_dm_q   <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 4'b0000;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         if_data_q  <= 32'h0;
         dm_rdata_q <= 32'h0;
      end else if (state_q == IDLE) begin
         if (if_ce_i || dm_ce_i) begin
            gnt_dm_q <= pick_dm;
            cnt_q    <= 4'(WAIT_CYCLES);
            if (pick_dm) begin
               we_q    <= dm_we_i;
               sel_q   <= dm_sel_i;
               addr_q  <= dm_addr_i;
               wdata_q <= dm_wdata_i;
            end else begin
               we_q    <= 1'b0;
               sel_q   <= 4'b1111;
               addr_q  <= if_addr_i;
               wdata_q <= 32'h0;
            end
         end
      end else if (in_access) begin
         if (cnt_q == 4'd0) begin
            // Stores complete the RAM cycle but leave load data untouched.
            if (!we_q) begin
               if (gnt_dm_q)
                  dm_rdata_q <= ram_rdata_i;
               else
                  if_data_q  <= ram_rdata_i;
            end
         end else begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   assign if_data_o  = if_data_q;
   assign dm_rdata_o = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0 sharing clock and reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        if_ce, dm_ce, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, ram_rdata;
   logic [3:0]  dm_sel;
   logic [31:0] if_data, dm_rdata, ram_addr, ram_wdata;
   logic        if_ready, dm_ready, ram_ce, ram_we, stall;
   logic [3:0]  ram_sel;

   logic        if0_ce, dm0_ce, dm0_we;
   logic [31:0] if0_addr, dm0_addr, dm0_wdata, ram0_rdata;
   logic [3:0]  dm0_sel;
   logic [31:0] if0_data, dm0_rdata, ram0_addr, ram0_wdata;
   logic        if0_ready, dm0_ready, ram0_ce, ram0_we, stall0;
   logic [3:0]  ram0_sel;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign ram0_rdata = ram0_addr + 32'h1000_0000;

   mem_port_arbiter #(.WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst),
      .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
      .dm_ce_i(dm_ce), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
      .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
      .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .stallreq_o(stall)
   );

   mem_port_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .if_ce_i(if0_ce), .if_addr_i(if0_addr), .if_data_o(if0_data), .if_ready_o(if0_ready),
      .dm_ce_i(dm0_ce), .dm_we_i(dm0_we), .dm_sel_i(dm0_sel), .dm_addr_i(dm0_addr),
      .dm_wdata_i(dm0_wdata), .dm_rdata_o(dm0_rdata), .dm_ready_o(dm0_ready),
      .ram_ce_o(ram0_ce), .ram_we_o(ram0_we), .ram_sel_o(ram0_sel), .ram_addr_o(ram0_addr),
      .ram_wdata_o(ram0_wdata), .ram_rdata_i(ram0_rdata), .stallreq_o(stall0)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_ce = 0; if_addr = 0; dm_ce = 0; dm_we = 0; dm_sel = 0; dm_addr = 0;
      dm_wdata = 0; ram_rdata = 0;
      if0_ce = 0; if0_addr = 0; dm0_ce = 0; dm0_we = 0; dm0_sel = 0; dm0_addr = 0;
      dm0_wdata = 0;
   endtask

   task automatic do_reset(input string tag);
      clear_inputs();
      rst = 1'b0;
      #1;
      chk({tag, "_rst_if_data"},  if_data, 32'h0);
      chk({tag, "_rst_dm_rdata"}, dm_rdata, 32'h0);
      chk({tag, "_rst_ready"},    {30'h0, if_ready, dm_ready}, 32'h0);
      chk({tag, "_rst_ram"},      {30'h0, ram_ce, ram_we} | ram_addr, 32'h0);
      repeat (2) cyc();
      rst = 1'b1;
   endtask

   initial begin
      int n;
      clear_inputs();
      #1;
      chk("por_stall", {31'h0, stall}, 32'h0);
      do_reset("t0");

      // Single fetch, WAIT_CYCLES=2.
      if_ce = 1; if_addr = 32'h100; ram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("f_idle_stall", {31'h0, stall}, 32'h1);
      chk("f_idle_ram_ce", {31'h0, ram_ce}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("f_acc%0d_ce", i), {31'h0, ram_ce}, 32'h1);
         chk($sformatf("f_acc%0d_addr", i), ram_addr, 32'h100);
         chk($sformatf("f_acc%0d_we_sel", i), {27'h0, ram_we, ram_sel}, 32'h0F);
         chk($sformatf("f_acc%0d_ready", i), {30'h0, if_ready, dm_ready}, 32'h0);
         if_addr = 32'h999;
      end
      cyc();
      chk("f_resp_ready", {30'h0, if_ready, dm_ready}, 32'h2);
      chk("f_resp_data",  if_data, 32'hDEAD_BEEF);
      chk("f_resp_ram_ce", {31'h0, ram_ce}, 32'h0);
      chk("f_resp_stall", {31'h0, stall}, 32'h0);
      if_ce = 0;
      cyc();
      chk("f_idle_ready", {30'h0, if_ready, dm_ready}, 32'h0);
      chk("f_data_hold",  if_data, 32'hDEAD_BEEF);

      // Store: RAM driven with the write, load data left alone.
      do_reset("t1");
      dm_ce = 1; dm_we = 1; dm_sel = 4'b0011; dm_addr = 32'h204; dm_wdata = 32'h0000_ABCD;
      ram_rdata = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("s_acc%0d_ce_we_sel", i), {26'h0, ram_ce, ram_we, ram_sel}, 32'h33);
         chk($sformatf("s_acc%0d_addr", i), ram_addr, 32'h204);
         chk($sformatf("s_acc%0d_wdata", i), ram_wdata, 32'h0000_ABCD);
      end
      cyc();
      chk("s_resp_ready", {30'h0, if_ready, dm_ready}, 32'h1);
      chk("s_resp_rdata", dm_rdata, 32'h0);
      dm_ce = 0;
      cyc();
      chk("s_after_ready", {30'h0, if_ready, dm_ready}, 32'h0);
      chk("s_after_rdata", dm_rdata, 32'h0);

      // Simultaneous requests held for two transactions.
      do_reset("t2");
      if_ce = 1; if_addr = 32'h300;
      dm_ce = 1; dm_we = 0; dm_sel = 4'hF; dm_addr = 32'h400;
      ram_rdata = 32'h1234_5678;
      cyc();
      chk("a1_addr", ram_addr, 32'h400);
      repeat (3) cyc();
      chk("a1_ready", {30'h0, if_ready, dm_ready}, 32'h1);
      chk("a1_rdata", dm_rdata, 32'h1234_5678);
      chk("a1_stall", {31'h0, stall}, 32'h1);
      cyc();
      chk("a2_idle_ram_ce", {31'h0, ram_ce}, 32'h0);
      cyc();
`ifdef ARB_FAIR_EN
      chk("a2_addr", ram_addr, 32'h300);
`else
      chk("a2_addr", ram_addr, 32'h400);
`endif
      repeat (3) cyc();
`ifdef ARB_FAIR_EN
      chk("a2_ready", {30'h0, if_ready, dm_ready}, 32'h2);
      chk("a2_if_data", if_data, 32'h1234_5678);
`else
      chk("a2_ready", {30'h0, if_ready, dm_ready}, 32'h1);
      chk("a2_if_data", if_data, 32'h0);
`endif
      if_ce = 0; dm_ce = 0;
      cyc();

      // Reset on the second ACCESS cycle aborts; held fetch restarts.
      do_reset("t3");
      if_ce = 1; if_addr = 32'h500; ram_rdata = 32'hCAFE_F00D;
      repeat (2) cyc();
      chk("r_acc2_ce", {31'h0, ram_ce}, 32'h1);
      rst = 1'b0;
      #1;
      chk("r_abort_ram", {30'h0, ram_ce, ram_we} | ram_addr, 32'h0);
      chk("r_abort_out", {29'h0, if_ready, dm_ready, stall}, 32'h0);
      chk("r_abort_data", if_data, 32'h0);
      cyc();
      chk("r_hold_ready", {30'h0, if_ready, dm_ready}, 32'h0);
      rst = 1'b1;
      n = 0;
      while (!if_ready && n < 20) begin
         cyc();
         n++;
      end
      chk("r_relatency", n, 4);
      chk("r_redata", if_data, 32'hCAFE_F00D);
      if_ce = 0;
      cyc();

      // WAIT_CYCLES=0 back-to-back loads.
      do_reset("t4");
      dm0_ce = 1; dm0_we = 0; dm0_sel = 4'hF; dm0_addr = 32'h0;
      #1;
      for (int c = 0; c < 6; c++) begin
         logic exp_rdy;
         logic exp_ce;
         exp_rdy = (c == 2 || c == 5);
         exp_ce  = (c == 1 || c == 4);
         chk($sformatf("z%0d_ready", c), {31'h0, dm0_ready}, {31'h0, exp_rdy});
         chk($sformatf("z%0d_stall", c), {31'h0, stall0}, {31'h0, ~exp_rdy});
         chk($sformatf("z%0d_ram_ce", c), {31'h0, ram0_ce}, {31'h0, exp_ce});
         if (c == 4) chk("z4_addr", ram0_addr, 32'h4);
         if (c == 2) begin
            chk("z2_rdata", dm0_rdata, 32'h1000_0000);
            dm0_addr = 32'h4;
         end
         if (c == 5) begin
            chk("z5_rdata", dm0_rdata, 32'h1000_0004);
            dm0_ce = 0;
         end
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
